imem_rsp: RTL and testbench

IMEM_RSP -- requirements
Module: imem_rsp

---
 rtl/imem_rsp_pkg.sv | 20 ++
 rtl/imem_rsp_if.sv | 28 ++
 rtl/imem_pipe.sv | 44 ++++
 rtl/sizes.vh | 8 +
 rtl/imem_rsp.sv | 87 ++++++++
 tb/tb_imem_rsp.sv | 203 ++++++++++++++++++++
 6 files changed

// File: rtl/imem_rsp_pkg.sv
// Shared types for the instruction-memory response path.
`include "sizes.vh"

package imem_rsp_pkg;

   localparam int SIZE_ADDR = `SIZE_ADDR;
   localparam int SIZE_DATA = `SIZE_DATA;

   typedef logic [`HBIT_ADDR:0] addr_t;
   typedef logic [`HBIT_DATA:0] data_t;

   // One response slot. Every field is zero whenever valid is zero.
   typedef struct packed {
      logic  valid;
      logic  err;
      addr_t pc;
      data_t data;
   } rsp_t;

endpackage

// File: rtl/imem_rsp_if.sv
// Fetch request / loader / response bundle between the fetch stage and imem_rsp.
// Handshake: iw_req is a one-cycle valid with no ready; every sampled request
// yields exactly one ow_valid pulse LATENCY cycles later, in order, and there
// is no backpressure. iw_we is an independent fire-and-forget loader write.
interface imem_rsp_if;
   import imem_rsp_pkg::*;

   addr_t iw_addr;
   logic  iw_req;
   logic  iw_flush;
   logic  iw_we;
   addr_t iw_waddr;
   data_t iw_wdata;
   data_t ow_data;
   addr_t ow_pc;
   logic  ow_valid;
   logic  ow_err;

   modport master (
      output iw_addr, iw_req, iw_flush, iw_we, iw_waddr, iw_wdata,
      input  ow_data, ow_pc, ow_valid, ow_err
   );

   modport slave (
      input  iw_addr, iw_req, iw_flush, iw_we, iw_waddr, iw_wdata,
      output ow_data, ow_pc, ow_valid, ow_err
   );
endinterface

// File: rtl/imem_pipe.sv
// Response delay line: STAGES registered slots after the array read register.
// Flush empties every slot; reset clears them asynchronously.
module imem_pipe
   import imem_rsp_pkg::*;
#(
   parameter int STAGES = 1
) (
   input  logic iw_clk,
   input  logic iw_rst,
   input  logic iw_flush,
   input  rsp_t in_rsp,
   output rsp_t out_rsp
);

   if (STAGES < 1) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{iw_clk, iw_rst, iw_flush};
      assign out_rsp = in_rsp;
   end else begin : g_stages
      rsp_t stage_q [STAGES];
      rsp_t stage_d [STAGES];

      // Shift one slot per cycle; a flush loads empty slots everywhere.
      always_comb begin
         for (int i = 0; i < STAGES; i++) stage_d[i] = '0;
         if (!iw_flush) begin
            stage_d[0] = in_rsp;
            for (int i = 1; i < STAGES; i++) stage_d[i] = stage_q[i-1];
         end
      end

      // Slot registers with asynchronous clear.
      always_ff @(posedge iw_clk or posedge iw_rst) begin
         if (iw_rst) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
         end else begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= stage_d[i];
         end
      end

      assign out_rsp = stage_q[STAGES-1];
   end

endmodule

// File: rtl/sizes.vh
// Shared datapath widths for the fetch path.
`ifndef SIZES_VH
`define SIZES_VH
`define SIZE_ADDR 24
`define HBIT_ADDR 23
`define SIZE_DATA 24
`define HBIT_DATA 23
`endif

// File: rtl/imem_rsp.sv
// Instruction memory with fixed-latency, non-stallable fetch responses and a
// side loader write port. Out-of-range fetches answer with err and zero data.
module imem_rsp
   import imem_rsp_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2
) (
   input  logic         iw_clk,
   input  logic         iw_rst,
   imem_rsp_if.slave    bus
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("imem_rsp: LATENCY must be in 1..4");
   end

   // In range iff no address bit above the array index is set.
   function automatic logic in_range(input addr_t a);
      return (a >> DEPTH_LOG2) == '0;
   endfunction

   data_t mem [DEPTH];
   data_t rd_q;

   logic  v1_q, v1_d;
   logic  err1_q, err1_d;
   addr_t pc1_q, pc1_d;
   logic  rd_en, wr_en;
   rsp_t  s1_rsp;
   rsp_t  out_rsp;

   // Request decode: a flush drops the request sampled on the same edge;
   // loader writes are blocked only by reset or an out-of-range address.
   always_comb begin
      v1_d   = bus.iw_req & ~bus.iw_flush;
      err1_d = v1_d & ~in_range(bus.iw_addr);
      pc1_d  = v1_d ? bus.iw_addr : '0;
      rd_en  = v1_d & in_range(bus.iw_addr);
      wr_en  = bus.iw_we & ~iw_rst & in_range(bus.iw_waddr);
   end

   // First response stage: valid/err/pc alongside the array read register.
   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         v1_q   <= 1'b0;
         err1_q <= 1'b0;
         pc1_q  <= '0;
      end else begin
         v1_q   <= v1_d;
         err1_q <= err1_d;
         pc1_q  <= pc1_d;
      end
   end

   // Block-RAM style array: registered read, unreset contents, read-first on
   // a same-word read/write because both use the pre-edge array value.
   always_ff @(posedge iw_clk) begin
      if (wr_en) mem[bus.iw_waddr[DEPTH_LOG2-1:0]] <= bus.iw_wdata;
      if (rd_en) rd_q <= mem[bus.iw_addr[DEPTH_LOG2-1:0]];
   end

   // Zero the data field unless this slot holds a good fetch.
   always_comb begin
      s1_rsp       = '0;
      s1_rsp.valid = v1_q;
      s1_rsp.err   = err1_q;
      s1_rsp.pc    = pc1_q;
      s1_rsp.data  = (v1_q & ~err1_q) ? rd_q : '0;
   end

   imem_pipe #(.STAGES(LATENCY - 1)) u_pipe (
      .iw_clk   (iw_clk),
      .iw_rst   (iw_rst),
      .iw_flush (bus.iw_flush),
      .in_rsp   (s1_rsp),
      .out_rsp  (out_rsp)
   );

   assign bus.ow_valid = out_rsp.valid;
   assign bus.ow_err   = out_rsp.err;
   assign bus.ow_pc    = out_rsp.pc;
   assign bus.ow_data  = out_rsp.data;

endmodule

// File: tb/tb_imem_rsp.sv
// Bench for imem_rsp: three instances (LATENCY 1, 2, 4; DEPTH_LOG2 4) driven
// with identical directed vectors; per-lane expected queues with due cycles.
module tb_imem_rsp;
   import imem_rsp_pkg::*;

   typedef struct {
      int    due;
      addr_t pc;
      data_t data;
      logic  err;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic iw_clk = 1'b0;
   logic iw_rst;
   always #5 iw_clk = ~iw_clk;

   int cyc = 0;
   always @(posedge iw_clk) cyc <= cyc + 1;

   // ---------------- DUTs ----------------
   logic  d_req, d_flush, d_we;
   addr_t d_addr, d_waddr;
   data_t d_wdata;

   imem_rsp_if bus_l1();
   imem_rsp_if bus_l2();
   imem_rsp_if bus_l4();

   assign bus_l1.iw_req = d_req;   assign bus_l2.iw_req = d_req;   assign bus_l4.iw_req = d_req;
   assign bus_l1.iw_addr = d_addr; assign bus_l2.iw_addr = d_addr; assign bus_l4.iw_addr = d_addr;
   assign bus_l1.iw_flush = d_flush; assign bus_l2.iw_flush = d_flush; assign bus_l4.iw_flush = d_flush;
   assign bus_l1.iw_we = d_we;     assign bus_l2.iw_we = d_we;     assign bus_l4.iw_we = d_we;
   assign bus_l1.iw_waddr = d_waddr; assign bus_l2.iw_waddr = d_waddr; assign bus_l4.iw_waddr = d_waddr;
   assign bus_l1.iw_wdata = d_wdata; assign bus_l2.iw_wdata = d_wdata; assign bus_l4.iw_wdata = d_wdata;

   imem_rsp #(.DEPTH_LOG2(4), .LATENCY(1)) dut_l1 (.iw_clk(iw_clk), .iw_rst(iw_rst), .bus(bus_l1.slave));
   imem_rsp #(.DEPTH_LOG2(4), .LATENCY(2)) dut_l2 (.iw_clk(iw_clk), .iw_rst(iw_rst), .bus(bus_l2.slave));
   imem_rsp #(.DEPTH_LOG2(4), .LATENCY(4)) dut_l4 (.iw_clk(iw_clk), .iw_rst(iw_rst), .bus(bus_l4.slave));

   logic  o_valid [3];
   logic  o_err   [3];
   addr_t o_pc    [3];
   data_t o_data  [3];
   assign o_valid[0] = bus_l1.ow_valid; assign o_err[0] = bus_l1.ow_err;
   assign o_pc[0]    = bus_l1.ow_pc;    assign o_data[0] = bus_l1.ow_data;
   assign o_valid[1] = bus_l2.ow_valid; assign o_err[1] = bus_l2.ow_err;
   assign o_pc[1]    = bus_l2.ow_pc;    assign o_data[1] = bus_l2.ow_data;
   assign o_valid[2] = bus_l4.ow_valid; assign o_err[2] = bus_l4.ow_err;
   assign o_pc[2]    = bus_l4.ow_pc;    assign o_data[2] = bus_l4.ow_data;

   // ---------------- scoreboard state ----------------
   int    lat [3] = '{1, 2, 4};
   exp_t  exp_q [3][$];
   data_t exp_mem [16];
   int    tests = 0;
   int    fails = 0;
   bit    run = 1'b0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void chk_idle(input string tag);
      for (int l = 0; l < 3; l++)
         chk($sformatf("%s lane%0d outputs", tag, l),
             {15'd0, o_valid[l], o_err[l], o_pc[l], o_data[l]}, 64'd0);
   endfunction

   // ---------------- driver ----------------
   // Drive one cycle of inputs, update the model at the sampling edge.
   task automatic step(input logic req, input addr_t addr, input logic flush,
                       input logic we, input addr_t waddr, input data_t wdata);
      int   k;
      exp_t e;
      d_req = req; d_addr = addr; d_flush = flush;
      d_we = we; d_waddr = waddr; d_wdata = wdata;
      @(posedge iw_clk);
      k = cyc;
      if (!iw_rst) begin
         for (int l = 0; l < 3; l++) begin
            if (flush) begin
               while (exp_q[l].size() > 0 && exp_q[l][$].due > k) void'(exp_q[l].pop_back());
            end else if (req) begin
               e.due  = k + lat[l];
               e.pc   = addr;
               e.err  = (addr >= 24'd16);
               e.data = e.err ? 24'd0 : exp_mem[addr[3:0]];
               exp_q[l].push_back(e);
            end
         end
         if (we && waddr < 24'd16) exp_mem[waddr[3:0]] = wdata;
      end
      #1;
      d_req = 1'b0; d_addr = '0; d_flush = 1'b0;
      d_we = 1'b0; d_waddr = '0; d_wdata = '0;
   endtask

   task automatic fetch(input addr_t addr);
      step(1'b1, addr, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic load(input addr_t waddr, input data_t wdata);
      step(1'b0, '0, 1'b0, 1'b1, waddr, wdata);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge iw_clk) begin : mon
      exp_t e;
      if (run) begin
         for (int l = 0; l < 3; l++) begin
            if (exp_q[l].size() > 0 && exp_q[l][0].due < cyc) begin
               tests++; fails++;
               $display("FAIL lane%0d missing: pc 0x%0h due cycle %0d, none by cycle %0d",
                        l, exp_q[l][0].pc, exp_q[l][0].due, cyc);
               void'(exp_q[l].pop_front());
            end
            if (o_valid[l]) begin
               if (exp_q[l].size() == 0) begin
                  tests++; fails++;
                  $display("FAIL lane%0d unexpected: valid=1 pc 0x%0h at cycle %0d, expected valid=0",
                           l, o_pc[l], cyc);
               end else begin
                  e = exp_q[l].pop_front();
                  chk($sformatf("lane%0d timing pc 0x%0h", l, e.pc), 64'(cyc), 64'(e.due));
                  chk($sformatf("lane%0d pc", l), 64'(o_pc[l]), 64'(e.pc));
                  chk($sformatf("lane%0d data pc 0x%0h", l, e.pc), 64'(o_data[l]), 64'(e.data));
                  chk($sformatf("lane%0d err pc 0x%0h", l, e.pc), 64'(o_err[l]), 64'(e.err));
               end
            end else begin
               chk($sformatf("lane%0d idle zero", l), {15'd0, o_err[l], o_pc[l], o_data[l]}, 64'd0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      iw_rst = 1'b1;
      d_req = 1'b0; d_addr = '0; d_flush = 1'b0;
      d_we = 1'b0; d_waddr = '0; d_wdata = '0;
      repeat (2) @(posedge iw_clk);
      #1 chk_idle("in reset");
      #2 iw_rst = 1'b0;
      run = 1'b1;

      // Load 0..15 with 0xA00000+i, then fetch them back-to-back.
      for (int i = 0; i < 16; i++) load(addr_t'(i), 24'hA00000 + data_t'(i));
      for (int i = 0; i < 16; i++) fetch(addr_t'(i));
      idle(5);

      // Out-of-range fetch; out-of-range write must not alias onto word 0.
      fetch(24'h000010);
      fetch(24'h800003);
      load(24'h000010, 24'hDEAD00);
      fetch(24'h000000);
      idle(5);

      // Read-first on the same word at the same edge.
      load(24'd3, 24'h111111);
      step(1'b1, 24'd3, 1'b0, 1'b1, 24'd3, 24'h222222);
      fetch(24'd3);
      idle(5);

      // Flush on the edge sampling the third request, with a loader write.
      fetch(24'd1);
      fetch(24'd2);
      step(1'b1, 24'd3, 1'b1, 1'b1, 24'd7, 24'h777777);
      idle(5);
      fetch(24'd7);
      fetch(24'd15);
      idle(5);

      // Asynchronous reset with two fetches in flight.
      fetch(24'd4);
      fetch(24'd5);
      #1 iw_rst = 1'b1;
      for (int l = 0; l < 3; l++) exp_q[l].delete();
      #1 chk_idle("async reset");
      load(24'd5, 24'h555555);
      idle(2);
      #2 iw_rst = 1'b0;
      fetch(24'd5);
      fetch(24'd6);
      idle(6);

      run = 1'b0;
      for (int l = 0; l < 3; l++)
         chk($sformatf("lane%0d queue drained", l), 64'(exp_q[l].size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
